// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state encoding and address-decode helper for the
// SRAM-backed AXI4 subordinate.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    // Offset compare avoids overflow when base + span would wrap past 2^32.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] span_bytes);
        return (addr >= base) && ((addr - base) < span_bytes);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for an AXI burst plus a flag for unsupported size/burst.
// WRAP and the reserved encoding advance like INCR but are reported as errors.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        err
);

    logic [31:0] step;
    logic        size_err;

    always_comb begin
        size_err  = (size > 3'd2);
        step      = size_err ? 32'd4 : (32'd1 << size);
        next_addr = addr + step;
        err       = size_err;
        case (burst)
            BURST_FIXED:       next_addr = addr;
            BURST_INCR:        next_addr = addr + step;
            BURST_WRAP, 2'b11: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 subordinate in front of a word-addressed SRAM; one transaction at a
// time with programmable read and write-response latency.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          MEM_WORDS  = 4096,
    parameter int          RD_LATENCY = 2,
    parameter int          WR_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awid_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o,
    output logic [3:0]  bid_o,
    input  logic        arvalid_i,
    output logic        arready_o,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arid_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic [3:0]  rid_o
);

    localparam int          IDX_W       = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES   = 32'(MEM_WORDS * 4);
    localparam logic [7:0]  RD_LAT_LAST = 8'(RD_LATENCY - 1);
    localparam logic [7:0]  WR_LAT_LAST = 8'(WR_LATENCY);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [3:0]  id_reg;
    logic [7:0]  len_reg;
    logic [2:0]  size_reg;
    logic [1:0]  burst_reg;
    logic [8:0]  beat_reg;
    logic [7:0]  lat_reg;
    logic        bresp_err_reg;
    logic        rd_oor_reg;
    logic        rd_err_reg;

    logic [31:0]      next_addr, rd_addr, rd_word;
    logic             burst_err, last_beat, rd_load, rd_in_range, wr_in_range;
    logic             ar_hs, aw_hs, r_hs, w_hs, wr_en, wr_beat_err;
    logic [IDX_W-1:0] rd_idx, wr_idx;

    axi_burst_addr u_burst_addr (
        .addr      (addr_reg),
        .size      (size_reg),
        .burst     (burst_reg),
        .next_addr (next_addr),
        .err       (burst_err)
    );

    assign ar_hs     = arvalid_i && arready_o;
    assign aw_hs     = awvalid_i && awready_o;
    assign r_hs      = rvalid_o && rready_i;
    assign w_hs      = wvalid_i && wready_o;
    assign last_beat = (beat_reg == {1'b0, len_reg});

    // The SRAM read is registered, so fetch the beat one cycle before it is shown.
    assign rd_addr     = (state_reg == ST_RD_DATA) ? next_addr : addr_reg;
    assign rd_in_range = addr_in_range(rd_addr, BASE_ADDR, MEM_BYTES);
    assign wr_in_range = addr_in_range(addr_reg, BASE_ADDR, MEM_BYTES);
    assign rd_idx      = IDX_W'((rd_addr - BASE_ADDR) >> 2);
    assign wr_idx      = IDX_W'((addr_reg - BASE_ADDR) >> 2);
    assign rd_load     = ((state_reg == ST_RD_WAIT) && (lat_reg == RD_LAT_LAST))
                       || (r_hs && !last_beat);
    assign wr_en       = w_hs && wr_in_range && (beat_reg <= {1'b0, len_reg});
    assign wr_beat_err = burst_err || !wr_in_range
                       || (wlast_i ? !last_beat : (beat_reg > {1'b0, len_reg}));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clock) begin
                if (wr_en && wstrb_i[gi]) begin
                    lane_mem[wr_idx] <= wdata_i[gi*8 +: 8];
                end
                if (rd_load) begin
                    lane_rd_reg <= lane_mem[rd_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // All outputs are forced low while reset is asserted, even mid-burst.
    always_comb begin
        state_next = state_reg;
        arready_o  = 1'b0;
        awready_o  = 1'b0;
        wready_o   = 1'b0;
        rvalid_o   = 1'b0;
        rlast_o    = 1'b0;
        rdata_o    = '0;
        rresp_o    = RESP_OKAY;
        rid_o      = '0;
        bvalid_o   = 1'b0;
        bresp_o    = RESP_OKAY;
        bid_o      = '0;
        case (state_reg)
            ST_IDLE: begin
                arready_o = !reset;
                awready_o = !reset && !arvalid_i;
                if (arvalid_i) begin
                    state_next = ST_RD_WAIT;
                end else if (awvalid_i) begin
                    state_next = ST_WR_DATA;
                end
            end
            ST_RD_WAIT: begin
                if (lat_reg == RD_LAT_LAST) begin
                    state_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rvalid_o = !reset;
                rlast_o  = !reset && last_beat;
                rdata_o  = (!reset && !rd_oor_reg) ? rd_word : '0;
                rresp_o  = (!reset && rd_err_reg) ? RESP_SLVERR : RESP_OKAY;
                rid_o    = reset ? '0 : id_reg;
                if (rready_i && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                wready_o = !reset;
                if (wvalid_i && wlast_i) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (lat_reg == WR_LAT_LAST) begin
                    bvalid_o = !reset;
                    bresp_o  = (!reset && bresp_err_reg) ? RESP_SLVERR : RESP_OKAY;
                    bid_o    = reset ? '0 : id_reg;
                    if (bready_i) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_reg      <= '0;
            id_reg        <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            burst_reg     <= '0;
            beat_reg      <= '0;
            lat_reg       <= '0;
            bresp_err_reg <= 1'b0;
            rd_oor_reg    <= 1'b0;
            rd_err_reg    <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                lat_reg <= '0;
            end else if ((state_reg == ST_RD_WAIT)
                         || ((state_reg == ST_WR_RESP) && (lat_reg != WR_LAT_LAST))) begin
                lat_reg <= lat_reg + 8'd1;
            end

            if (ar_hs) begin
                addr_reg  <= araddr_i;
                id_reg    <= arid_i;
                len_reg   <= arlen_i;
                size_reg  <= arsize_i;
                burst_reg <= arburst_i;
                beat_reg  <= '0;
            end else if (aw_hs) begin
                addr_reg      <= awaddr_i;
                id_reg        <= awid_i;
                len_reg       <= awlen_i;
                size_reg      <= awsize_i;
                burst_reg     <= awburst_i;
                beat_reg      <= '0;
                bresp_err_reg <= 1'b0;
            end

            if (rd_load) begin
                rd_oor_reg <= !rd_in_range;
                rd_err_reg <= !rd_in_range || burst_err;
            end

            // Beat count saturates so an overlong write burst stays flagged.
            if (r_hs || w_hs) begin
                addr_reg <= next_addr;
                if (!beat_reg[8]) begin
                    beat_reg <= beat_reg + 9'd1;
                end
            end

            if (w_hs && wr_beat_err) begin
                bresp_err_reg <= 1'b1;
            end
        end
    end

endmodule
